// File: rtl/nibble_deserializer_if.sv
// Bundle of the serial input, nibble outputs and comparator feedback for nibble_deserializer.
// slave is the deserializer side; master is the driver/comparator side.
interface nibble_deserializer_if #(
  parameter int CNT_W = 8
);
  logic             serial_in;
  logic             in_valid;
  logic             in_ready;
  logic             a;
  logic             b;
  logic             c;
  logic             d;
  logic             nibble_valid;
  logic             q_in;
  logic             match_pulse;
  logic [CNT_W-1:0] match_count;
  logic             count_clr;

  modport slave (
    input  serial_in, in_valid, q_in, count_clr,
    output in_ready, a, b, c, d, nibble_valid, match_pulse, match_count
  );

  modport master (
    output serial_in, in_valid, q_in, count_clr,
    input  in_ready, a, b, c, d, nibble_valid, match_pulse, match_count
  );
endinterface

// File: rtl/nibble_deserializer.sv
// Serial-to-nibble front end for the 0101 comparator, with a saturating match counter.
// Build option OVERLAP_EN: sliding 4-bit window instead of non-overlapping nibbles.
module nibble_deserializer #(
  parameter int CNT_W = 8
) (
  input logic                  clk,
  input logic                  rst,
  nibble_deserializer_if.slave bus
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             in_ready_reg, in_ready_next;
  logic [3:0]       abcd_reg, abcd_next;
  logic             nibble_valid_reg, nibble_valid_next;
  logic             match_pulse_reg, match_pulse_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             accept;

  assign accept = bus.in_valid && in_ready_reg;

  // q_in only means something while a fresh nibble is being presented
  always_comb begin
    match_pulse_next = nibble_valid_reg && bus.q_in;
    count_next       = count_reg;
    if (bus.count_clr) begin
      count_next = '0;
    end else if (match_pulse_next && (count_reg != CNT_MAX)) begin
      count_next = count_reg + 1'b1;
    end
  end

`ifdef OVERLAP_EN
  logic [1:0] seen_reg, seen_next;

  always_comb begin
    seen_next         = seen_reg;
    abcd_next         = abcd_reg;
    nibble_valid_next = 1'b0;
    in_ready_next     = 1'b1;
    if (accept) begin
      abcd_next = {abcd_reg[2:0], bus.serial_in};
      if (seen_reg == 2'd3) begin
        nibble_valid_next = 1'b1;
      end else begin
        seen_next = seen_reg + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seen_reg <= 2'd0;
    end else begin
      seen_reg <= seen_next;
    end
  end
`else
  typedef enum logic {COLLECT, PRESENT} state_t;

  state_t     state_reg, state_next;
  logic [1:0] bit_cnt_reg, bit_cnt_next;
  logic [2:0] sh_reg, sh_next;

  always_comb begin
    state_next        = state_reg;
    bit_cnt_next      = bit_cnt_reg;
    sh_next           = sh_reg;
    abcd_next         = abcd_reg;
    nibble_valid_next = 1'b0;
    in_ready_next     = 1'b1;
    case (state_reg)
      COLLECT: begin
        if (accept) begin
          sh_next      = {sh_reg[1:0], bus.serial_in};
          bit_cnt_next = bit_cnt_reg + 2'd1;
          if (bit_cnt_reg == 2'd3) begin
            abcd_next         = {sh_reg, bus.serial_in};
            nibble_valid_next = 1'b1;
            bit_cnt_next      = 2'd0;
            in_ready_next     = 1'b0;
            state_next        = PRESENT;
          end
        end
      end
      PRESENT: state_next = COLLECT;
      default: state_next = COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= COLLECT;
      bit_cnt_reg <= 2'd0;
      sh_reg      <= 3'd0;
    end else begin
      state_reg   <= state_next;
      bit_cnt_reg <= bit_cnt_next;
      sh_reg      <= sh_next;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready_reg     <= 1'b0;
      abcd_reg         <= 4'd0;
      nibble_valid_reg <= 1'b0;
      match_pulse_reg  <= 1'b0;
      count_reg        <= '0;
    end else begin
      in_ready_reg     <= in_ready_next;
      abcd_reg         <= abcd_next;
      nibble_valid_reg <= nibble_valid_next;
      match_pulse_reg  <= match_pulse_next;
      count_reg        <= count_next;
    end
  end

  assign bus.in_ready     = in_ready_reg;
  assign bus.a            = abcd_reg[3];
  assign bus.b            = abcd_reg[2];
  assign bus.c            = abcd_reg[1];
  assign bus.d            = abcd_reg[0];
  assign bus.nibble_valid = nibble_valid_reg;
  assign bus.match_pulse  = match_pulse_reg;
  assign bus.match_count  = count_reg;
endmodule

// File: tb/tb_nibble_deserializer.sv
// Scoreboard bench for nibble_deserializer: accepted nibbles are queued, popped when nibble_valid shows.
// Follows OVERLAP_EN the same way the design does.
module tb_nibble_deserializer;
  localparam int CNT_W = 2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic clk;
  logic rst;
  logic q_noise;

  nibble_deserializer_if #(.CNT_W(CNT_W)) bus ();

  nibble_deserializer #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Stand-in for the comparator; garbage on q_in whenever no nibble is presented
  assign bus.q_in = bus.nibble_valid ? ({bus.a, bus.b, bus.c, bus.d} == 4'b0101) : q_noise;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int               n_checks;
  int               n_fail;
  logic [3:0]       sb_q[$];
  logic [3:0]       held;
  logic [3:0]       tb_sh;
  int               nbits;
  logic             nv_exp;
  logic             pend_pulse;
  logic [CNT_W-1:0] m_count;
  logic             ready_en;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic reset_model();
    sb_q.delete();
    held       = 4'd0;
    tb_sh      = 4'd0;
    nbits      = 0;
    nv_exp     = 1'b0;
    pend_pulse = 1'b0;
    m_count    = '0;
    ready_en   = 1'b0;
  endtask

  // Asserted mid-cycle so the asynchronous clear is observable before any edge
  task automatic do_reset();
    bus.in_valid = 1'b0;
    #3 rst = 1'b1;
    #1;
    check_eq("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check_eq("rst_abcd", 32'({bus.a, bus.b, bus.c, bus.d}), 32'd0);
    check_eq("rst_nibble_valid", 32'(bus.nibble_valid), 32'd0);
    check_eq("rst_match_pulse", 32'(bus.match_pulse), 32'd0);
    check_eq("rst_match_count", 32'(bus.match_count), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    reset_model();
  endtask

  // One clock cycle: drive, check at negedge, advance the expectation model
  task automatic step(input logic v, input logic b, input logic clr);
    logic       exp_ready;
    logic       acc;
    logic       q;
    logic       nv_next;
    logic [3:0] nib;
    bus.in_valid  = v;
    bus.serial_in = b;
    bus.count_clr = clr;
    q_noise       = 1'($urandom_range(0, 1));
    @(negedge clk);
`ifdef OVERLAP_EN
    exp_ready = ready_en;
`else
    exp_ready = ready_en && !nv_exp;
`endif
    check_eq("in_ready", 32'(bus.in_ready), 32'(exp_ready));
    check_eq("nibble_valid", 32'(bus.nibble_valid), 32'(nv_exp));
    q = 1'b0;
    if (nv_exp) begin
      if (sb_q.size() == 0) begin
        check_eq("sb_underflow", 32'(sb_q.size()), 32'd1);
      end else begin
        nib  = sb_q.pop_front();
        held = nib;
        q    = (nib == 4'b0101);
        check_eq("nibble", 32'({bus.a, bus.b, bus.c, bus.d}), 32'(nib));
        $display("nibble %b match %0d count_before %0d", nib, q, m_count);
      end
    end
`ifdef OVERLAP_EN
    check_eq("abcd", 32'({bus.a, bus.b, bus.c, bus.d}), 32'(tb_sh));
`else
    check_eq("abcd", 32'({bus.a, bus.b, bus.c, bus.d}), 32'(held));
`endif
    check_eq("match_pulse", 32'(bus.match_pulse), 32'(pend_pulse));
    check_eq("match_count", 32'(bus.match_count), 32'(m_count));
    pend_pulse = q;
    if (clr) m_count = '0;
    else if (q && (m_count != CNT_MAX)) m_count = m_count + 1'b1;
    acc     = v && exp_ready;
    nv_next = 1'b0;
    if (acc) begin
      tb_sh = {tb_sh[2:0], b};
`ifdef OVERLAP_EN
      if (nbits < 4) nbits++;
      if (nbits == 4) begin
        sb_q.push_back(tb_sh);
        nv_next = 1'b1;
      end
`else
      nbits++;
      if (nbits == 4) begin
        sb_q.push_back(tb_sh);
        nv_next = 1'b1;
        nbits   = 0;
      end
`endif
    end
    nv_exp   = nv_next;
    ready_en = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Four bits back to back, one presentation cycle (bit driven but ignored), one pulse cycle
  task automatic send_nib(input logic [3:0] nib, input logic clr_present);
    for (int i = 3; i >= 0; i--) step(1'b1, nib[i], 1'b0);
    step(1'b1, ~nib[0], clr_present);
    step(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst           = 1'b0;
    q_noise       = 1'b0;
    bus.serial_in = 1'b0;
    bus.in_valid  = 1'b0;
    bus.count_clr = 1'b0;
    reset_model();
    do_reset();
    step(1'b0, 1'b0, 1'b0);

`ifdef OVERLAP_EN
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check_eq("ovl_count", 32'(bus.match_count), 32'd2);
`else
    send_nib(4'b0101, 1'b0);
    check_eq("match_count_one", 32'(bus.match_count), 32'd1);

    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check_eq("stall_abcd", 32'({bus.a, bus.b, bus.c, bus.d}), 32'hC);
    check_eq("stall_count", 32'(bus.match_count), 32'd1);

    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    do_reset();
    step(1'b0, 1'b0, 1'b0);
    send_nib(4'b0101, 1'b0);
    check_eq("post_rst_count", 32'(bus.match_count), 32'd1);

    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) send_nib(4'b0101, 1'b0);
    check_eq("sat_count", 32'(bus.match_count), 32'd3);
    send_nib(4'b0101, 1'b1);
    check_eq("clr_wins", 32'(bus.match_count), 32'd0);
`endif

    for (int i = 0; i < 1000; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
    end
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
